// File: rtl/shape_processor_modeling_pkg.sv
// Shared types for the shape processor control SFR and its bus initiator.
// Register image layout, response codes, initiator states and the write packing helper.
package shape_processor_modeling;

  typedef enum logic [1:0] {
    CIRCLE     = 2'd0,
    RECTANGLE  = 2'd1,
    TRIANGLE   = 2'd2,
    KEEP_SHAPE = 2'd3
  } shape_t;

  typedef enum logic [1:0] {
    ANGLES         = 2'd0,
    AREA           = 2'd1,
    PERIMETER      = 2'd2,
    KEEP_OPERATION = 2'd3
  } operation_t;

  typedef struct packed {
    logic [27:0] reserved;
    shape_t      shape;
    operation_t  operation;
  } ctrl_sfr_reg;

  typedef enum logic [1:0] {
    ST_OK       = 2'd0,
    ST_IGNORED  = 2'd1,
    ST_MISMATCH = 2'd2,
    ST_SYNC     = 2'd3
  } rsp_status_e;

  typedef enum logic [2:0] {
    SYNC_RD,
    SYNC_WAIT,
    IDLE,
    WR,
    RD,
    RD_WAIT,
    RESP
  } ctrl_state_e;

  // Builds the 32-bit ctrl_sfr_reg image; reserved bits are always written as zero.
  function automatic logic [31:0] pack_ctrl(input shape_t shape, input operation_t operation);
    ctrl_sfr_reg img;
    img           = '0;
    img.shape     = shape;
    img.operation = operation;
    return img;
  endfunction

endpackage

// File: rtl/shape_processor_readback_cmp.sv
// Merges the commanded fields with the shadow copy (KEEP_* selects the shadow field)
// and classifies a readback word as OK, IGNORED or MISMATCH.
module shape_processor_readback_cmp
  import shape_processor_modeling::*;
(
  input  shape_t      cmd_shape,
  input  operation_t  cmd_operation,
  input  ctrl_sfr_reg shadow,
  input  logic [31:0] readback,
  output rsp_status_e status
);

  shape_t      exp_shape;
  operation_t  exp_operation;
  logic [31:0] expected;

  always_comb begin
    // NOTE: every variable gets a value before any branch so no latch is inferred.
    status        = ST_MISMATCH;
    exp_shape     = (cmd_shape == KEEP_SHAPE) ? shadow.shape : cmd_shape;
    exp_operation = (cmd_operation == KEEP_OPERATION) ? shadow.operation : cmd_operation;
    expected      = pack_ctrl(exp_shape, exp_operation);
    // A no-op write has expected == shadow, so the OK test must come first.
    if (readback == expected) begin
      status = ST_OK;
    end else if (readback == shadow) begin
      status = ST_IGNORED;
    end
  end

endmodule

// File: rtl/shape_processor_ctrl_initiator.sv
// Bus initiator for the shape processor control SFR: syncs a shadow copy after reset,
// then per command writes, reads back, classifies (with bounded retries) and responds.
module shape_processor_ctrl_initiator
  import shape_processor_modeling::*;
#(
  parameter int READ_LATENCY = 1,
  parameter int MAX_RETRIES  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  shape_t      cmd_shape,
  input  operation_t  cmd_operation,
  output logic        write,
  output logic [31:0] write_data,
  output logic        read,
  input  logic [31:0] read_data,
  input  logic        error,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output rsp_status_e rsp_status,
  output logic        rsp_error,
  output logic [31:0] rsp_read_data
);

  // The sync read is issued from SYNC_WAIT's first cycle, so it waits one cycle more than RD_WAIT.
  localparam logic [2:0] RD_LAST   = 3'(READ_LATENCY - 1);
  localparam logic [2:0] SYNC_LAST = 3'(READ_LATENCY);
  localparam logic [2:0] RETRY_MAX = 3'(MAX_RETRIES);

  ctrl_state_e state;
  shape_t      cmd_shape_q;
  operation_t  cmd_operation_q;
  logic [31:0] shadow;
  logic [2:0]  lat_cnt;
  logic [2:0]  retry_cnt;
  logic        err_acc;
  logic        resp_first;
  rsp_status_e cmp_status;

  shape_processor_readback_cmp u_cmp (
    .cmd_shape     (cmd_shape_q),
    .cmd_operation (cmd_operation_q),
    .shadow        (shadow),
    .readback      (read_data),
    .status        (cmp_status)
  );

  // NOTE: all state here uses non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= SYNC_RD;
      cmd_ready       <= 1'b0;
      write           <= 1'b0;
      write_data      <= '0;
      read            <= 1'b0;
      rsp_valid       <= 1'b0;
      rsp_status      <= ST_OK;
      rsp_error       <= 1'b0;
      rsp_read_data   <= '0;
      cmd_shape_q     <= CIRCLE;
      cmd_operation_q <= ANGLES;
      shadow          <= '0;
      lat_cnt         <= '0;
      retry_cnt       <= '0;
      err_acc         <= 1'b0;
      resp_first      <= 1'b0;
    end else begin
      case (state)
        SYNC_RD: begin
          read    <= 1'b1;
          err_acc <= error;
          lat_cnt <= '0;
          state   <= SYNC_WAIT;
        end
        SYNC_WAIT: begin
          read    <= 1'b0;
          err_acc <= err_acc | error;
          if (lat_cnt == SYNC_LAST) begin
            shadow        <= read_data;
            rsp_read_data <= read_data;
            rsp_status    <= ST_SYNC;
            rsp_error     <= err_acc | error;
            rsp_valid     <= 1'b1;
            resp_first    <= 1'b1;
            state         <= RESP;
          end else begin
            lat_cnt <= lat_cnt + 3'd1;
          end
        end
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready       <= 1'b0;
            cmd_shape_q     <= cmd_shape;
            cmd_operation_q <= cmd_operation;
            retry_cnt       <= '0;
            err_acc         <= 1'b0;
            write           <= 1'b1;
            write_data      <= pack_ctrl(cmd_shape, cmd_operation);
            state           <= WR;
          end
        end
        WR: begin
          write      <= 1'b0;
          write_data <= '0;
          read       <= 1'b1;
          err_acc    <= err_acc | error;
          state      <= RD;
        end
        RD: begin
          read    <= 1'b0;
          err_acc <= err_acc | error;
          lat_cnt <= '0;
          state   <= RD_WAIT;
        end
        RD_WAIT: begin
          err_acc <= err_acc | error;
          if (lat_cnt == RD_LAST) begin
            // IGNORED implies readback == shadow, so the shadow always tracks the readback.
            shadow <= read_data;
            if (cmp_status == ST_MISMATCH && retry_cnt < RETRY_MAX) begin
              retry_cnt  <= retry_cnt + 3'd1;
              write      <= 1'b1;
              write_data <= pack_ctrl(cmd_shape_q, cmd_operation_q);
              state      <= WR;
            end else begin
              rsp_read_data <= read_data;
              rsp_status    <= cmp_status;
              rsp_error     <= err_acc | error;
              rsp_valid     <= 1'b1;
              resp_first    <= 1'b1;
              state         <= RESP;
            end
          end else begin
            lat_cnt <= lat_cnt + 3'd1;
          end
        end
        RESP: begin
          resp_first <= 1'b0;
          // A late error pulse one cycle after capture still belongs to this transaction.
          if (resp_first) begin
            rsp_error <= rsp_error | error;
          end
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= SYNC_RD;
      endcase
    end
  end

endmodule
